// File: rtl/h_serializer_if.sv
// h_serializer_if: load/stream bundle between the lstm array and the hidden-state consumer
interface h_serializer_if #(
   parameter int WIDTH    = 32,
   parameter int NUM_LSTM = 8
);
   logic                      load;
   logic [NUM_LSTM*WIDTH-1:0] i_h;
   logic                      i_ready;
   logic [WIDTH-1:0]          o_data;
   logic                      o_valid;
   logic [WIDTH-1:0]          o_addr;
   logic                      o_busy;
   logic                      o_done;
   logic                      o_overrun;
   modport slave (
      input  load, i_h, i_ready,
      output o_data, o_valid, o_addr, o_busy, o_done, o_overrun
   );
   modport master (
      output load, i_h, i_ready,
      input  o_data, o_valid, o_addr, o_busy, o_done, o_overrun
   );
endinterface

// File: rtl/h_serializer.sv
// h_serializer: captures a NUM_LSTM-lane hidden vector and streams it one word per handshake; H_SKID_EN adds a pending-frame buffer
module h_serializer #(
   parameter int WIDTH          = 32,
   parameter int NUM_LSTM       = 8,
   parameter int NUM_ITERATIONS = 8
) (
   input logic           clk,
   input logic           rst,
   h_serializer_if.slave bus
);
   localparam int LW = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
   localparam int SW = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;
   typedef enum logic {IDLE, SEND} state_t;
   state_t                    r_state, w_state;
   logic [LW-1:0]             r_lane, w_lane;
   logic [SW-1:0]             r_step, w_step;
   logic [NUM_LSTM*WIDTH-1:0] r_frame, w_frame;
   logic                      r_done, w_done;
   logic                      r_ovr, w_ovr;
   logic                      w_xfer, w_last, w_wrap;
`ifdef H_SKID_EN
   logic [NUM_LSTM*WIDTH-1:0] r_pend, w_pend;
   logic                      r_pend_v, w_pend_v;
`endif
   assign w_xfer = (r_state == SEND) && bus.i_ready;
   assign w_last = w_xfer && (r_lane == LW'(NUM_LSTM - 1));
   assign w_wrap = (r_step == SW'(NUM_ITERATIONS - 1));
   // state, counters and frame register; reset abandons any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_lane   <= '0;
         r_step   <= '0;
         r_frame  <= '0;
         r_done   <= 1'b0;
         r_ovr    <= 1'b0;
`ifdef H_SKID_EN
         r_pend   <= '0;
         r_pend_v <= 1'b0;
`endif
      end else begin
         r_state  <= w_state;
         r_lane   <= w_lane;
         r_step   <= w_step;
         r_frame  <= w_frame;
         r_done   <= w_done;
         r_ovr    <= w_ovr;
`ifdef H_SKID_EN
         r_pend   <= w_pend;
         r_pend_v <= w_pend_v;
`endif
      end
   end
   // next state: capture on load in IDLE, advance lane per transfer, close frame on last lane
   always_comb begin
      w_state  = r_state;
      w_lane   = r_lane;
      w_step   = r_step;
      w_frame  = r_frame;
      w_done   = 1'b0;
      w_ovr    = r_ovr;
`ifdef H_SKID_EN
      w_pend   = r_pend;
      w_pend_v = r_pend_v;
`endif
      if (r_state == IDLE) begin
         if (bus.load) begin
            w_state = SEND;
            w_frame = bus.i_h;
            w_lane  = '0;
         end
      end else begin
         if (w_xfer) w_lane = r_lane + 1'b1;
         if (w_last) begin
            w_lane  = '0;
            w_step  = w_wrap ? '0 : r_step + 1'b1;
            w_done  = w_wrap;
            w_state = IDLE;
         end
`ifdef H_SKID_EN
         if (w_last && r_pend_v) begin
            w_state  = SEND;
            w_frame  = r_pend;
            w_pend_v = 1'b0;
         end
         if (bus.load) begin
            if (r_pend_v) begin
               w_ovr = 1'b1;
            end else if (w_last) begin
               w_state = SEND;
               w_frame = bus.i_h;
            end else begin
               w_pend   = bus.i_h;
               w_pend_v = 1'b1;
            end
         end
`else
         if (bus.load) w_ovr = 1'b1;
`endif
      end
   end
   assign bus.o_data    = r_frame[r_lane*WIDTH +: WIDTH];
   assign bus.o_addr    = WIDTH'(r_step) * WIDTH'(NUM_LSTM) + WIDTH'(r_lane);
   assign bus.o_valid   = (r_state == SEND);
   assign bus.o_busy    = (r_state == SEND);
   assign bus.o_done    = r_done;
   assign bus.o_overrun = r_ovr;
endmodule

// File: tb/tb_h_serializer.sv
// tb_h_serializer: directed plus random stimulus against a frame-queue reference model
module tb_h_serializer;
   localparam int W  = 32;
   localparam int NL = 8;
   localparam int NI = 8;
`ifdef H_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif
   typedef struct packed {logic [W-1:0] d; logic [W-1:0] a;} word_t;
   logic clk, rst;
   int n_tests, n_fail;
   word_t q[$];
   int m_fc;
   logic m_done, m_ovr;
   logic [NL*W-1:0] h;
   h_serializer_if #(.WIDTH(W), .NUM_LSTM(NL)) bus ();
   h_serializer #(.WIDTH(W), .NUM_LSTM(NL), .NUM_ITERATIONS(NI)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push_frame(input logic [NL*W-1:0] v);
      for (int k = 0; k < NL; k++) q.push_back('{v[k*W +: W], W'((m_fc % NI) * NL + k)});
      m_fc++;
   endtask
   // one clock: drive at negedge, check outputs, advance model, cross the edge
   task automatic cyc(input logic ld, input logic [NL*W-1:0] v, input logic rdy);
      int fl;
      word_t w;
      bus.load = ld; bus.i_h = v; bus.i_ready = rdy;
      #1;
      chk("valid", 64'(bus.o_valid), 64'(q.size() > 0));
      chk("busy", 64'(bus.o_busy), 64'(q.size() > 0));
      chk("done", 64'(bus.o_done), 64'(m_done));
      chk("overrun", 64'(bus.o_overrun), 64'(m_ovr));
      if (q.size() > 0) begin
         chk("data", 64'(bus.o_data), 64'(q[0].d));
         chk("addr", 64'(bus.o_addr), 64'(q[0].a));
      end
      fl = (q.size() + NL - 1) / NL;
      m_done = 1'b0;
      if (rdy && q.size() > 0) begin
         w = q.pop_front();
         m_done = (w.a == W'(NI * NL - 1));
      end
      if (ld) begin
         if (fl <= SKID) push_frame(v);
         else m_ovr = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_rst();
      rst = 1'b1;
      #1;
      chk("rst_valid", 64'(bus.o_valid), 64'd0);
      chk("rst_busy", 64'(bus.o_busy), 64'd0);
      chk("rst_done", 64'(bus.o_done), 64'd0);
      chk("rst_ovr", 64'(bus.o_overrun), 64'd0);
      chk("rst_data", 64'(bus.o_data), 64'd0);
      chk("rst_addr", 64'(bus.o_addr), 64'd0);
      q.delete(); m_fc = 0; m_done = 1'b0; m_ovr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) cyc(1'b0, '0, 1'b1);
      chk("drain_timeout", 64'(q.size()), 64'd0);
      cyc(1'b0, '0, 1'b1);
   endtask
   function automatic logic [NL*W-1:0] rnd_vec();
      logic [NL*W-1:0] v;
      for (int k = 0; k < NL; k++) v[k*W +: W] = $urandom;
      return v;
   endfunction
   initial begin
      n_tests = 0; n_fail = 0; m_fc = 0; m_done = 1'b0; m_ovr = 1'b0;
      rst = 1'b1; bus.load = 1'b0; bus.i_h = '0; bus.i_ready = 1'b0;
      @(negedge clk);
      do_rst();
      for (int k = 0; k < NL; k++) h[k*W +: W] = W'(8'h11 * (k + 1));
      cyc(1'b1, h, 1'b1);
      drain();
      cyc(1'b1, rnd_vec(), 1'b1);
      for (int i = 0; i < 16; i++) cyc(1'b0, '0, (i % 2) == 0);
      drain();
      do_rst();
      for (int f = 0; f < NI + 1; f++) begin
         cyc(1'b1, rnd_vec(), 1'b1);
         for (int i = 0; i < NL; i++) cyc(1'b0, '0, 1'b1);
      end
      drain();
      do_rst();
      cyc(1'b1, rnd_vec(), 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
      cyc(1'b1, rnd_vec(), 1'b1);
      cyc(1'b1, rnd_vec(), 1'b1);
      drain();
      do_rst();
      cyc(1'b1, rnd_vec(), 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
      chk("at_lane5", 64'(bus.o_addr), 64'd5);
      do_rst();
      for (int k = 0; k < NL; k++) h[k*W +: W] = (k % 2 == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      cyc(1'b1, h, 1'b1);
      drain();
      do_rst();
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 3) == 0, rnd_vec(), $urandom_range(0, 3) != 0);
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/h_serializer.md
# h_serializer

Output-side converter for the LSTM forward array: captures the parallel hidden-state vector `o_h` (NUM_LSTM lanes of WIDTH bits) on a load strobe and streams it out one WIDTH-bit word per handshake. Each word carries a flat write address of step*NUM_LSTM + lane. It is the counterpart of the input path (address counter, x memory, shift register, storage register), which turns a serial word stream into a parallel vector. Sits between the `lstm` instance and the hidden-state memory or backpropagation consumer.

## Interface
- WIDTH, 32, word width, signed fixed-point; passed through unmodified
- NUM_LSTM, 8, lanes per hidden vector (words per frame)
- NUM_ITERATIONS, 8, time steps per sequence (frames per sequence)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load  in  1  capture `i_h` as a new frame
- i_h  in  NUM_LSTM*WIDTH  hidden vector; lane k = i_h[(k+1)*WIDTH-1 : k*WIDTH]
- i_ready  in  1  consumer accepts `o_data` this cycle
- o_data  out  WIDTH  current word
- o_valid  out  1  `o_data`/`o_addr` valid
- o_addr  out  WIDTH  step*NUM_LSTM + lane, zero-extended
- o_busy  out  1  frame in progress (state SEND)
- o_done  out  1  one-cycle pulse after the last word of step NUM_ITERATIONS-1
- o_overrun  out  1  sticky; a load was dropped

## Operation
- States: IDLE, SEND.
- IDLE + load: capture i_h into the frame register, lane=0, go to SEND.
- SEND: o_valid=1, o_data=lane `lane` of the frame register.
  - A transfer occurs when o_valid && i_ready; each transfer does lane++.
  - Transfer at lane==NUM_LSTM-1: frame complete, lane=0, step++.
  - If step was NUM_ITERATIONS-1, step wraps to 0 and o_done pulses the next cycle.
  - Then return to IDLE, or start the pending frame (see Configuration).
- Word order: lane 0 (LSBs of i_h) first, lane NUM_LSTM-1 last.
- o_data must hold stable while o_valid && !i_ready.
- Load in SEND with no buffer available: load dropped, o_overrun set; cleared only by rst.
- Load in IDLE at the same edge o_done is high: accepted normally.
- rst mid-frame: frame abandoned; state, counters and flags cleared at once.

## Timing
- Reset values: o_data=0, o_valid=0, o_addr=0, o_busy=0, o_done=0, o_overrun=0; lane=0, step=0, frame register=0.
- Latency: load at edge N gives o_valid=1 with lane 0 from cycle N+1.
- Throughput: with i_ready held high, one word per cycle.
  - A frame takes NUM_LSTM cycles.
  - o_valid drops for exactly one cycle between frames (back-to-back frames only with H_SKID_EN).
- o_busy equals o_valid; both registered outputs.
- o_addr updates in the same cycle as o_data.

## Configuration
- H_SKID_EN defined: adds one pending-frame register.
  - Load during SEND with pending empty: captures i_h into pending, no overrun.
  - After the final transfer, pending moves to the frame register and SEND continues with lane 0 on the next cycle, with no idle gap.
  - Load while pending is full: dropped, o_overrun set.
  - Load on the same cycle as the final transfer with pending empty: becomes the next frame directly.
- H_SKID_EN undefined: no pending register; every load during SEND is dropped and sets o_overrun.

## Test plan
- Reset, then load with lanes 0..7 = 0x11,0x22,...,0x88 and i_ready=1 -> o_data 0x11..0x88 on 8 consecutive cycles; o_addr 0..7; then o_valid=0.
- i_ready toggles 1,0,1,0 in the same frame -> each word held while i_ready=0; no word lost or duplicated; o_addr still 0..7.
- 8 frames back to back (NUM_ITERATIONS=8) -> o_addr runs 0..63; o_done high exactly one cycle after address 63; next frame restarts at o_addr 0.
- Without H_SKID_EN, load at lane 3 -> o_overrun=1, current frame unaffected. With H_SKID_EN, the second frame follows immediately at o_addr 8; a third load in the same frame sets o_overrun.
- rst asserted while at lane 5 -> all outputs 0 asynchronously; the next load starts at o_addr 0.
- Signed data 0x80000000 and 0xFFFFFFFF -> passed bit-exact.
